// File: rtl/button_event_detector_if.sv
// Button event detector bus: debounced level and thresholds in, events and duration out.
interface button_event_detector_if #(
  parameter int unsigned COUNTER_WIDTH = 16
);
  logic                     button;
  logic [COUNTER_WIDTH-1:0] long_press_ticks;
  logic [COUNTER_WIDTH-1:0] repeat_ticks;
  logic                     repeat_enable;
  logic                     press_evt;
  logic                     release_evt;
  logic                     long_press_evt;
  logic                     repeat_evt;
  logic                     held;
  logic [COUNTER_WIDTH-1:0] press_duration;

  // Side that drives the button and thresholds and consumes the events.
  modport master (
    output button, long_press_ticks, repeat_ticks, repeat_enable,
    input  press_evt, release_evt, long_press_evt, repeat_evt, held, press_duration
  );

  // The detector itself.
  modport slave (
    input  button, long_press_ticks, repeat_ticks, repeat_enable,
    output press_evt, release_evt, long_press_evt, repeat_evt, held, press_duration
  );
endinterface

// File: rtl/button_event_detector.sv
// Turns one debounced button level into press / release / long-press / auto-repeat pulses
// and reports the tick-count duration of the last completed press.
module button_event_detector #(
  parameter int unsigned TICK_DIVIDER  = 100000,
  parameter int unsigned COUNTER_WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst,
  button_event_detector_if.slave bus
);

  localparam int unsigned PW = $clog2(TICK_DIVIDER);
  localparam logic [PW-1:0] PrescMax = PW'(TICK_DIVIDER - 1);
  localparam logic [COUNTER_WIDTH-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StPressed, StHeld} state_e;

  state_e                   state_q, state_d;
  logic                     btn_q;
  logic [PW-1:0]            presc_q, presc_d;
  logic [COUNTER_WIDTH-1:0] hold_q, hold_d;
  logic [COUNTER_WIDTH-1:0] rep_q, rep_d;
  logic [COUNTER_WIDTH-1:0] dur_q, dur_d;
  logic                     press_q, press_d;
  logic                     rel_q, rel_d;
  logic                     long_q, long_d;
  logic                     rpt_q, rpt_d;
  logic                     held_q;

  logic                     tick;
  logic                     rep_on;
  logic                     long_hit;
  logic [COUNTER_WIDTH-1:0] hold_inc;
  logic [COUNTER_WIDTH-1:0] rep_inc;

  assign tick     = (presc_q == PrescMax);
  assign hold_inc = (hold_q == CntMax) ? hold_q : hold_q + COUNTER_WIDTH'(1);
  assign rep_inc  = (rep_q == CntMax) ? rep_q : rep_q + COUNTER_WIDTH'(1);
  assign rep_on   = bus.repeat_enable && (bus.repeat_ticks != '0);
  assign long_hit = (bus.long_press_ticks != '0) && (hold_inc >= bus.long_press_ticks);

  // Single input register; the FSM only ever looks at btn_q.
  always_ff @(posedge clk) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= bus.button;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; a release always takes priority over a threshold crossing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (btn_q) state_d = StPressed;
      StPressed: begin
        if (!btn_q)               state_d = StIdle;
        else if (tick && long_hit) state_d = StHeld;
      end
      StHeld:    if (!btn_q) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Counter updates and event pulse decode.
  always_comb begin
    presc_d = presc_q;
    hold_d  = hold_q;
    rep_d   = rep_q;
    dur_d   = dur_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    case (state_q)
      StIdle: begin
        presc_d = '0;
        if (btn_q) begin
          press_d = 1'b1;
          hold_d  = '0;
        end
      end
      StPressed, StHeld: begin
        if (!btn_q) begin
          // A tick landing on the release cycle still completes that tick of the reported
          // duration (floor(N/TICK_DIVIDER)), but raises no long/repeat event.
          rel_d   = 1'b1;
          dur_d   = tick ? hold_inc : hold_q;
          presc_d = '0;
        end else begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (state_q == StHeld && !rep_on) rep_d = '0;
          if (tick) begin
            hold_d = hold_inc;
            if (state_q == StPressed) begin
              if (long_hit) begin
                long_d = 1'b1;
                rep_d  = '0;
              end
            end else if (rep_on) begin
              if (rep_inc >= bus.repeat_ticks) begin
                rpt_d = 1'b1;
                rep_d = '0;
              end else begin
                rep_d = rep_inc;
              end
            end
          end
        end
      end
      default: presc_d = '0;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      hold_q  <= '0;
      rep_q   <= '0;
      dur_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      dur_q   <= dur_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
      held_q  <= (state_d == StHeld);
    end
  end

  assign bus.press_evt      = press_q;
  assign bus.release_evt    = rel_q;
  assign bus.long_press_evt = long_q;
  assign bus.repeat_evt     = rpt_q;
  assign bus.held           = held_q;
  assign bus.press_duration = dur_q;

endmodule
